// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: registered ALU-control decoder with an iterative multiply/divide
// sequencer that drives the HI/LO result registers. Sits in the EX stage, between
// the main control unit and the datapath ALU.
//
// Optional feature macro: ALU_SEQ_SIGNED_MD_EN
//   When it is defined, signed MULT (funct 011000) and DIV (funct 011010) are
//   decoded. The operands are converted to magnitudes when the request is accepted,
//   the unsigned core does the work, and a FIXUP state applies the signs before DONE.
//   When it is undefined, those two functs decode as illegal and FIXUP is not built.
//
// Handshake:
//   - A request is accepted on a rising edge where in_valid && in_ready.
//   - in_ready is high only in IDLE. Requests offered while busy are ignored,
//     not queued, so the upstream stage must hold them.
//   - out_valid is a one-cycle pulse.
//   - md_done qualifies out_valid as a mult/div result in hi/lo.
//   - illegal qualifies out_valid as an undecodable request.
//   - dbg_state exposes the FSM state.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [3:0]  ILLEGAL_CODE = 4'b0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [1:0]       aluOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       aluOpOut,
  output logic             out_valid,
  output logic             md_done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       dbg_state
);

  // Shared ALU-code definitions
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // I-type opcodes decoded when aluOp = 11
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam int unsigned       CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
`ifdef ALU_SEQ_SIGNED_MD_EN
    S_FIXUP = 3'd4,
`endif
    S_DONE  = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    K_ALU = 2'd0,
    K_MUL = 2'd1,
    K_DIV = 2'd2,
    K_ILL = 2'd3
  } kind_t;

  state_t               r_state;
  logic [3:0]           r_code;
  logic                 r_out_valid;
  logic                 r_md_done;
  logic                 r_illegal;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  // Shared work register.
  //   MUL: {partial product high, multiplier shifting out}
  //   DIV: {remainder, dividend shifting out / quotient shifting in}
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;       // multiplicand or divisor
  logic [CW-1:0]        r_cnt;

  kind_t                w_kind;
  logic [3:0]           w_code;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH:0]       w_div_diff;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_rem;
  logic [2*WIDTH-1:0]   w_div_next;

`ifdef ALU_SEQ_SIGNED_MD_EN
  logic                 w_sgn;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic                 r_sgn;
  logic                 r_neg_p;      // product/quotient must be negated
  logic                 r_neg_r;      // remainder must be negated (sign of a)
  logic                 r_is_div;
`endif

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign aluOpOut  = r_code;
  assign out_valid = r_out_valid;
  assign md_done   = r_md_done;
  assign illegal   = r_illegal;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

  // Decode the request into an operation kind and a 4-bit ALU code
  always_comb begin
    w_kind = K_ILL;
    w_code = ILLEGAL_CODE;
`ifdef ALU_SEQ_SIGNED_MD_EN
    w_sgn  = 1'b0;
`endif
    case (aluOp)
      2'b00: begin w_kind = K_ALU; w_code = ALU_ADD; end
      2'b01: begin w_kind = K_ALU; w_code = ALU_SUB; end
      2'b10: begin
        case (funct)
          6'b000000: begin w_kind = K_ALU; w_code = ALU_SLL; end
          6'b000010: begin w_kind = K_ALU; w_code = ALU_SRL; end
          6'b100000: begin w_kind = K_ALU; w_code = ALU_ADD; end
          6'b100010: begin w_kind = K_ALU; w_code = ALU_SUB; end
          6'b100100: begin w_kind = K_ALU; w_code = ALU_AND; end
          6'b100101: begin w_kind = K_ALU; w_code = ALU_OR;  end
          6'b100111: begin w_kind = K_ALU; w_code = ALU_NOR; end
          6'b101010: begin w_kind = K_ALU; w_code = ALU_SLT; end
          6'b011001: w_kind = K_MUL;
          6'b011011: w_kind = K_DIV;
`ifdef ALU_SEQ_SIGNED_MD_EN
          6'b011000: begin w_kind = K_MUL; w_sgn = 1'b1; end
          6'b011010: begin w_kind = K_DIV; w_sgn = 1'b1; end
`endif
          default: ;
        endcase
      end
      default: begin
        case (opcode)
          OP_ANDI: begin w_kind = K_ALU; w_code = ALU_AND; end
          OP_ORI:  begin w_kind = K_ALU; w_code = ALU_OR;  end
          OP_SLTI: begin w_kind = K_ALU; w_code = ALU_SLT; end
          OP_ADDI: begin w_kind = K_ALU; w_code = ALU_ADD; end
          default: ;
        endcase
      end
    endcase
  end

`ifdef ALU_SEQ_SIGNED_MD_EN
  // Signed requests run on magnitudes; the signs are re-applied in FIXUP
  assign w_a_neg = w_sgn & a[WIDTH-1];
  assign w_b_neg = w_sgn & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? ({WIDTH{1'b0}} - a) : a;
  assign w_b_mag = w_b_neg ? ({WIDTH{1'b0}} - b) : b;
`else
  assign w_a_mag = a;
  assign w_b_mag = b;
`endif

  // Shift-add step: add the multiplicand to the high half when the multiplier LSB
  // is set, then shift the whole product right by one
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring-division step: shift in the next dividend bit, then subtract the
  // divisor if it fits
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ge    = ~w_div_diff[WIDTH];
  assign w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

  // Control FSM with registered outputs; hi/lo are written only on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_code      <= 4'b0000;
      r_out_valid <= 1'b0;
      r_md_done   <= 1'b0;
      r_illegal   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_cnt       <= '0;
`ifdef ALU_SEQ_SIGNED_MD_EN
      r_sgn       <= 1'b0;
      r_neg_p     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_is_div    <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      r_md_done   <= 1'b0;
      r_illegal   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            case (w_kind)
              K_ALU: begin
                r_code      <= w_code;
                r_out_valid <= 1'b1;
              end
              K_MUL: begin
                r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                r_opnd  <= w_a_mag;
                r_cnt   <= '0;
                r_state <= S_MUL;
              end
              K_DIV: begin
                if (b == '0) begin
                  // Divide by zero completes immediately, with no iterations
                  r_hi        <= a;
                  r_lo        <= '1;
                  r_out_valid <= 1'b1;
                  r_md_done   <= 1'b1;
                  r_state     <= S_DONE;
                end else begin
                  r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                  r_opnd  <= w_b_mag;
                  r_cnt   <= '0;
                  r_state <= S_DIV;
                end
              end
              default: begin
                r_code      <= ILLEGAL_CODE;
                r_out_valid <= 1'b1;
                r_illegal   <= 1'b1;
              end
            endcase
`ifdef ALU_SEQ_SIGNED_MD_EN
            r_sgn    <= w_sgn;
            r_neg_p  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_is_div <= (w_kind == K_DIV);
`endif
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
`ifdef ALU_SEQ_SIGNED_MD_EN
            if (r_sgn) begin
              r_state <= S_FIXUP;
            end else begin
              {r_hi, r_lo} <= w_mul_next;
              r_out_valid  <= 1'b1;
              r_md_done    <= 1'b1;
              r_state      <= S_DONE;
            end
`else
            {r_hi, r_lo} <= w_mul_next;
            r_out_valid  <= 1'b1;
            r_md_done    <= 1'b1;
            r_state      <= S_DONE;
`endif
          end
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
`ifdef ALU_SEQ_SIGNED_MD_EN
            if (r_sgn) begin
              r_state <= S_FIXUP;
            end else begin
              r_hi        <= w_div_next[2*WIDTH-1:WIDTH];
              r_lo        <= w_div_next[WIDTH-1:0];
              r_out_valid <= 1'b1;
              r_md_done   <= 1'b1;
              r_state     <= S_DONE;
            end
`else
            r_hi        <= w_div_next[2*WIDTH-1:WIDTH];
            r_lo        <= w_div_next[WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_md_done   <= 1'b1;
            r_state     <= S_DONE;
`endif
          end
        end
`ifdef ALU_SEQ_SIGNED_MD_EN
        S_FIXUP: begin
          if (r_is_div) begin
            r_lo <= r_neg_p ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
            r_hi <= r_neg_r ? ({WIDTH{1'b0}} - r_acc[2*WIDTH-1:WIDTH])
                            : r_acc[2*WIDTH-1:WIDTH];
          end else begin
            {r_hi, r_lo} <= r_neg_p ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;
          end
          r_out_valid <= 1'b1;
          r_md_done   <= 1'b1;
          r_state     <= S_DONE;
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl (WIDTH = 32). Expected values are computed
// by hand. Inputs are driven, and outputs sampled, 1 ns after each rising clock edge.
module tb_alu_seq_ctrl;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [1:0]    aluOp;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    aluOpOut;
  logic          out_valid;
  logic          md_done;
  logic          illegal;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [2:0]    dbg_state;

  int            n_pass;
  int            n_total;
  logic [3:0]    exp_code;
  logic [17:0]   tv [12];     // {aluOp, opcode, funct, expected code}
  logic [17:0]   vec;

  alu_seq_ctrl #(.WIDTH(W), .ILLEGAL_CODE(4'b0010)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct     (funct),
    .aluOp     (aluOp),
    .a         (a),
    .b         (b),
    .aluOpOut  (aluOpOut),
    .out_valid (out_valid),
    .md_done   (md_done),
    .illegal   (illegal),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issue one mult/div request, then check busy cycles, the completion and the
  // return to IDLE. lat is the accept-to-out_valid latency in cycles.
  task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input int lat);
    aluOp = 2'b10; funct = f; a = va; b = vb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    for (int i = 1; i < lat; i++) begin
      if (i == 5) begin in_valid = 1'b1; funct = 6'b111111; end
      if (i == 7) in_valid = 1'b0;
      chk({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy_ov"}, 32'(out_valid), 32'd0);
      step();
    end
    chk({tag, "_ov"}, 32'(out_valid), 32'd1);
    chk({tag, "_md"}, 32'(md_done), 32'd1);
    chk({tag, "_ill"}, 32'(illegal), 32'd0);
    chk({tag, "_code"}, 32'(aluOpOut), 32'(exp_code));
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    step();
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_hi_hold"}, hi, ehi);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    exp_code = 4'b0000;
    tv[0]  = {2'b00, 6'b000000, 6'b000000, 4'b0010};
    tv[1]  = {2'b01, 6'b000000, 6'b000000, 4'b0110};
    tv[2]  = {2'b10, 6'b000000, 6'b000000, 4'b0011};
    tv[3]  = {2'b10, 6'b000000, 6'b000010, 4'b0100};
    tv[4]  = {2'b10, 6'b000000, 6'b100000, 4'b0010};
    tv[5]  = {2'b10, 6'b000000, 6'b100010, 4'b0110};
    tv[6]  = {2'b10, 6'b000000, 6'b100101, 4'b0001};
    tv[7]  = {2'b10, 6'b000000, 6'b100111, 4'b1100};
    tv[8]  = {2'b11, 6'b001100, 6'b000000, 4'b0000};
    tv[9]  = {2'b11, 6'b001101, 6'b000000, 4'b0001};
    tv[10] = {2'b11, 6'b001000, 6'b000000, 4'b0010};
    tv[11] = {2'b11, 6'b001010, 6'b000000, 4'b0111};

    // Reset
    rst = 1'b1; in_valid = 1'b0; opcode = '0; funct = '0; aluOp = '0; a = '0; b = '0;
    step();
    step();
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_code", 32'(aluOpOut), 32'd0);
    chk("rst_md", 32'(md_done), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    step();

    // Back-to-back AND then SLT
    in_valid = 1'b1; aluOp = 2'b10; funct = 6'b100100;
    step();
    chk("and_ov", 32'(out_valid), 32'd1);
    chk("and_code", 32'(aluOpOut), 32'b0000);
    chk("and_rdy", 32'(in_ready), 32'd1);
    chk("and_md", 32'(md_done), 32'd0);
    funct = 6'b101010;
    step();
    chk("slt_ov", 32'(out_valid), 32'd1);
    chk("slt_code", 32'(aluOpOut), 32'b0111);
    chk("slt_rdy", 32'(in_ready), 32'd1);

    // Decode table, one request per cycle
    for (int i = 0; i < 12; i++) begin
      vec = tv[i];
      aluOp = vec[17:16]; opcode = vec[15:10]; funct = vec[9:4];
      step();
      chk("tbl_ov", 32'(out_valid), 32'd1);
      chk("tbl_ill", 32'(illegal), 32'd0);
      chk("tbl_code", 32'(aluOpOut), 32'(vec[3:0]));
    end
    in_valid = 1'b0;
    exp_code = 4'b0111;
    step();
    chk("idle_ov", 32'(out_valid), 32'd0);
    chk("idle_code_hold", 32'(aluOpOut), 32'(exp_code));

    // Unsigned multiply / divide
    run_md("multu_3x5", 6'b011001, 32'd3, 32'd5, 32'd0, 32'd15, 33);
    run_md("multu_max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_md("divu_17_5", 6'b011011, 32'd17, 32'd5, 32'd2, 32'd3, 33);
    run_md("divu_9_0", 6'b011011, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1);
    run_md("divu_max_16", 6'b011011, 32'hFFFF_FFFF, 32'd16, 32'hF, 32'h0FFF_FFFF, 33);
    run_md("divu_5_7", 6'b011011, 32'd5, 32'd7, 32'd5, 32'd0, 33);

    // Illegal requests: hi = 5, lo = 0 must be left alone
    in_valid = 1'b1; aluOp = 2'b10; funct = 6'b111111;
    step();
    exp_code = 4'b0010;
    chk("ill_f_ov", 32'(out_valid), 32'd1);
    chk("ill_f_ill", 32'(illegal), 32'd1);
    chk("ill_f_md", 32'(md_done), 32'd0);
    chk("ill_f_code", 32'(aluOpOut), 32'(exp_code));
    chk("ill_f_hi", hi, 32'd5);
    chk("ill_f_lo", lo, 32'd0);
    aluOp = 2'b11; opcode = 6'b000000;
    step();
    chk("ill_op_ov", 32'(out_valid), 32'd1);
    chk("ill_op_ill", 32'(illegal), 32'd1);
    in_valid = 1'b0;
    step();
    chk("ill_ov_clr", 32'(out_valid), 32'd0);

`ifdef ALU_SEQ_SIGNED_MD_EN
    run_md("div_m7_2", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run_md("mult_m3_5", 6'b011000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34);
    run_md("mult_m4_m6", 6'b011000, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'd0, 32'd24, 34);
    run_md("div_m9_0", 6'b011010, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1);
    run_md("divu_5_7b", 6'b011011, 32'd5, 32'd7, 32'd5, 32'd0, 33);
`else
    // Signed functs are undecodable in this build
    in_valid = 1'b1; aluOp = 2'b10; funct = 6'b011000; a = 32'd3; b = 32'd4;
    step();
    chk("mult_ill", 32'(illegal), 32'd1);
    chk("mult_ill_rdy", 32'(in_ready), 32'd1);
    funct = 6'b011010;
    step();
    chk("div_ill", 32'(illegal), 32'd1);
    chk("div_ill_hi", hi, 32'd5);
    in_valid = 1'b0;
    step();
`endif

    // Reset in the middle of a MULTU
    in_valid = 1'b1; aluOp = 2'b10; funct = 6'b011001; a = 32'd7; b = 32'd9;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("mid_no_ov", 32'(out_valid), 32'd0);
    end
    chk("mid_lo_clear", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
